// File: rtl/rr_arbiter8.sv
// Eight-way round-robin arbiter: registered one-hot grant plus binary index for the 3-to-8 decoder.
// Optional `ARB_LOCK_EN adds a lock input that suppresses the MAX_HOLD rotation while asserted.
module rr_arbiter8 #(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned HW       = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
`ifdef ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [7:0] gnt,
  output logic [2:0] gnt_idx,
  output logic       gnt_valid,
  output logic       timeout
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam bit            LIMIT_EN = (MAX_HOLD != 0);
  localparam logic [HW-1:0] HOLD_LIM = HW'(MAX_HOLD);
  localparam logic [HW-1:0] CNT_MAX  = '1;

  state_t        state;
  logic [2:0]    ptr;
  logic [HW-1:0] hold_cnt;

  logic       lock_on;
  logic       owner_req;
  logic       at_limit;
  logic       revoke;
  logic       keep;
  logic [7:0] cand;
  logic       found;
  logic [2:0] win;

  // Circular scan from start; returns {found, index}.
  function automatic logic [3:0] rr_pick(input logic [7:0] v, input logic [2:0] start);
    logic [3:0] r;
    logic [2:0] i;
    r = '0;
    for (int unsigned k = 0; k < 8; k++) begin
      i = start + k[2:0];
      if (!r[3] && v[i]) r = {1'b1, i};
    end
    return r;
  endfunction

`ifdef ARB_LOCK_EN
  assign lock_on = lock;
`else
  assign lock_on = 1'b0;
`endif

  always_comb begin
    owner_req = req[gnt_idx];
    // >= rather than == so that a lock held past the limit still revokes once dropped.
    at_limit  = LIMIT_EN && (hold_cnt >= HOLD_LIM);
    revoke    = at_limit && !lock_on;
    keep      = owner_req && !revoke;
    cand      = (state == GRANT) ? (req & ~(8'b1 << gnt_idx)) : req;
    {found, win} = rr_pick(cand, ptr);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      hold_cnt  <= '0;
      gnt       <= '0;
      gnt_idx   <= '0;
      gnt_valid <= 1'b0;
      timeout   <= 1'b0;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE: begin
          if (found) begin
            state     <= GRANT;
            gnt       <= 8'b1 << win;
            gnt_idx   <= win;
            gnt_valid <= 1'b1;
            hold_cnt  <= HW'(1);
            ptr       <= win + 3'd1;
          end
        end
        GRANT: begin
          if (keep) begin
            if (hold_cnt != CNT_MAX) hold_cnt <= hold_cnt + 1'b1;
          end else begin
            timeout <= owner_req && revoke;
            if (found) begin
              gnt      <= 8'b1 << win;
              gnt_idx  <= win;
              hold_cnt <= HW'(1);
              ptr      <= win + 3'd1;
            end else begin
              state     <= IDLE;
              gnt       <= '0;
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
              hold_cnt  <= '0;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rr_arbiter8.sv
// Directed bench for rr_arbiter8: four instances with different MAX_HOLD, expectations queued per step.
module tb_rr_arbiter8;

  logic       clk;
  logic       rst_n;
  logic       lock;
  logic [7:0] req_d, req_r, req_h, req_l;
  logic [7:0] g_d, g_r, g_h, g_l;
  logic [2:0] i_d, i_r, i_h, i_l;
  logic       v_d, v_r, v_h, v_l;
  logic       t_d, t_r, t_h, t_l;
  int unsigned sel;
  logic [12:0] obs;

  typedef struct {
    logic [12:0] exp;
    string       tag;
  } exp_t;
  exp_t sb[$];

  int compared;
  int mism;

  rr_arbiter8 #(.MAX_HOLD(16), .HW(5)) u_dflt (
    .clk(clk), .rst_n(rst_n), .req(req_d),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(g_d), .gnt_idx(i_d), .gnt_valid(v_d), .timeout(t_d));

  rr_arbiter8 #(.MAX_HOLD(4), .HW(3)) u_rot (
    .clk(clk), .rst_n(rst_n), .req(req_r),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(g_r), .gnt_idx(i_r), .gnt_valid(v_r), .timeout(t_r));

  rr_arbiter8 #(.MAX_HOLD(3), .HW(2)) u_hog (
    .clk(clk), .rst_n(rst_n), .req(req_h),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(g_h), .gnt_idx(i_h), .gnt_valid(v_h), .timeout(t_h));

  rr_arbiter8 #(.MAX_HOLD(2), .HW(3)) u_lk (
    .clk(clk), .rst_n(rst_n), .req(req_l),
`ifdef ARB_LOCK_EN
    .lock(lock),
`endif
    .gnt(g_l), .gnt_idx(i_l), .gnt_valid(v_l), .timeout(t_l));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always_comb begin
    case (sel)
      1:       obs = {g_r, i_r, v_r, t_r};
      2:       obs = {g_h, i_h, v_h, t_h};
      3:       obs = {g_l, i_l, v_l, t_l};
      default: obs = {g_d, i_d, v_d, t_d};
    endcase
  end

  // Queue the expectation for the coming edge, then compare once the DUT has updated.
  task automatic step(input string tag, input logic [7:0] eg, input logic [2:0] ei,
                      input logic ev, input logic et);
    exp_t e;
    e.exp = {eg, ei, ev, et};
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    compared++;
    assert (obs === e.exp) else begin
      mism++;
      $error("FAIL %s: observed gnt=%h idx=%0d valid=%b timeout=%b, expected gnt=%h idx=%0d valid=%b timeout=%b",
             e.tag, obs[12:5], obs[4:2], obs[1], obs[0],
             e.exp[12:5], e.exp[4:2], e.exp[1], e.exp[0]);
    end
  endtask

  task automatic hold(input string tag, input int unsigned idx, input logic to);
    step(tag, 8'(1 << idx), 3'(idx), 1'b1, to);
  endtask

  task automatic none(input string tag, input logic to);
    step(tag, 8'h00, 3'd0, 1'b0, to);
  endtask

  initial begin
    compared = 0;
    mism     = 0;
    sel      = 0;
    lock     = 1'b0;
    req_r    = '0;
    req_h    = '0;
    req_l    = '0;

    // Reset with every requester active
    rst_n = 1'b0;
    req_d = 8'hFF;
    none("reset_0", 1'b0);
    none("reset_1", 1'b0);
    rst_n = 1'b1;
    hold("first_grant", 0, 1'b0);
    req_d = 8'h00;
    none("first_release", 1'b0);

    // Single requester held for 5 cycles
    req_d = 8'h10;
    for (int i = 0; i < 5; i++) hold("single_hold", 4, 1'b0);
    req_d = 8'h00;
    none("single_release", 1'b0);

    // Pointer fairness: 2 owns, then 7 beats 0 because ptr sits at 3
    req_d = 8'h04;
    hold("pf_grant2", 2, 1'b0);
    req_d = 8'h85;
    hold("pf_no_preempt", 2, 1'b0);
    req_d = 8'h81;
    hold("pf_next7", 7, 1'b0);
    req_d = 8'h01;
    hold("pf_wrap0", 0, 1'b0);
    req_d = 8'h00;
    none("pf_idle", 1'b0);

    // Reset mid-grant clears the pointer
    req_d = 8'h20;
    hold("mid_grant5", 5, 1'b0);
    rst_n = 1'b0;
    none("mid_reset", 1'b0);
    rst_n = 1'b1;
    req_d = 8'hFF;
    hold("ptr_cleared", 0, 1'b0);
    req_d = 8'h00;
    none("post_reset_idle", 1'b0);

    // Rotation, MAX_HOLD=4, all requesting
    sel   = 1;
    req_r = 8'hFF;
    for (int k = 0; k < 9; k++)
      for (int c = 0; c < 4; c++)
        hold("rotation", k % 8, (c == 0 && k > 0));
    req_r = 8'h00;
    none("rotation_end", 1'b0);

    // Lone hog, MAX_HOLD=3
    sel   = 2;
    req_h = 8'h08;
    for (int i = 0; i < 3; i++) hold("hog_hold", 3, 1'b0);
    none("hog_timeout_gap", 1'b1);
    for (int i = 0; i < 3; i++) hold("hog_regrant", 3, 1'b0);
    none("hog_timeout_gap2", 1'b1);
    req_h = 8'h00;
    none("hog_idle", 1'b0);

    // MAX_HOLD=2 with two requesters
    sel   = 3;
    req_l = 8'h03;
`ifdef ARB_LOCK_EN
    lock = 1'b1;
    for (int i = 0; i < 5; i++) hold("lock_hold0", 0, 1'b0);
    lock = 1'b0;
    hold("lock_release1", 1, 1'b1);
`else
    hold("lk_hold0_a", 0, 1'b0);
    hold("lk_hold0_b", 0, 1'b0);
    hold("lk_switch1", 1, 1'b1);
`endif
    hold("lk_hold1", 1, 1'b0);
    hold("lk_back0", 0, 1'b1);
    req_l = 8'h00;
    none("lk_idle", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mism);
    $finish;
  end

endmodule
